io_timer_responder: RTL

- Memory-mapped two-channel timer/counter peripheral for the Minisys 32-bit CPU.
- Acts as the responder end of the IORead/IOWrite path produced by the control unit. The address decoder asserts `cs` for the 0xFFFFFC20–0xFFFFFC27 window.
- Each channel counts down from a CPU-loaded initial value:
  - timer mode: one tick per clock;
  - counter mode: one tick per synchronized rising edge of an external pulse.
- Terminal count is reported through status bits and a one-cycle output pulse.

---
 rtl/io_timer_responder_if.sv | 15 +
 rtl/io_timer_responder.sv | 113 +++++++++++
 2 files changed

// File: rtl/io_timer_responder_if.sv
// CPU-side IORead/IOWrite bus for the timer responder.
// The master drives the strobes, address and write data; the slave returns read data.
interface io_timer_responder_if #(
    parameter int CNT_W = 16
);
    logic             cs;
    logic             iord;
    logic             iowr;
    logic [2:0]       addr;
    logic [CNT_W-1:0] wdata;
    logic [CNT_W-1:0] rdata;

    modport master (output cs, iord, iowr, addr, wdata, input rdata);
    modport slave  (input cs, iord, iowr, addr, wdata, output rdata);
endinterface

// File: rtl/io_timer_responder.sv
// Two-channel memory-mapped down-counting timer/counter for the Minisys IO window.
// Each channel ticks on the clock (timer) or on a synchronized external edge (counter).
module io_timer_responder #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    io_timer_responder_if.slave bus,
    input  logic                pulse0,
    input  logic                pulse1,
    output logic                cout0,
    output logic                cout1
);
    typedef enum logic {IDLE, RUN} state_t;

    logic                  rd_en;
    logic                  wr_en;
    logic [1:0]            pulse_in;
    logic [1:0]            cout_all;
    logic [1:0][CNT_W-1:0] status_all;
    logic [1:0][CNT_W-1:0] count_all;
    logic                  addr_unused;

    assign rd_en       = bus.cs & bus.iord;
    assign wr_en       = bus.cs & bus.iowr;
    assign pulse_in    = {pulse1, pulse0};
    assign addr_unused = bus.addr[0];
    assign cout0       = cout_all[0];
    assign cout1       = cout_all[1];

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_t                 state;
        logic [1:0]             mode;
        logic [CNT_W-1:0]       init;
        logic [CNT_W-1:0]       count;
        logic [1:0]             done;
        logic [SYNC_STAGES-1:0] sync;
        logic                   edge_q;
        logic                   cout;
        logic                   tick;
        logic                   mode_wr;
        logic                   init_wr;
        logic                   stat_rd;

        assign mode_wr = wr_en && (bus.addr[2:1] == 2'(ch));
        assign init_wr = wr_en && (bus.addr[2:1] == 2'(ch + 2));
        assign stat_rd = rd_en && (bus.addr[2:1] == 2'(ch));
        assign tick    = mode[0] ? (sync[SYNC_STAGES-1] & ~edge_q) : 1'b1;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state  <= IDLE;
                mode   <= '0;
                init   <= '0;
                count  <= '0;
                done   <= '0;
                sync   <= '0;
                edge_q <= 1'b0;
                cout   <= 1'b0;
            end else begin
                sync   <= {sync[SYNC_STAGES-2:0], pulse_in[ch]};
                edge_q <= sync[SYNC_STAGES-1];
                cout   <= 1'b0;
                // Priority: mode write, then init write (drops any tick), then
                // read-clear, with a terminal tick re-setting done last so it wins.
                if (mode_wr) begin
                    mode  <= bus.wdata[1:0];
                    done  <= '0;
                    state <= IDLE;
                end else if (init_wr) begin
                    init  <= bus.wdata;
                    count <= bus.wdata;
                    state <= (bus.wdata != '0) ? RUN : IDLE;
                end else begin
                    if (stat_rd) begin
                        done <= '0;
                    end
                    if (state == RUN && tick) begin
                        if (count > CNT_W'(1)) begin
                            count <= count - CNT_W'(1);
                        end else begin
                            cout          <= 1'b1;
                            done[mode[0]] <= 1'b1;
                            if (mode[1]) begin
                                count <= init;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                            end
                        end
                    end
                end
            end
        end

        assign cout_all[ch]   = cout;
        assign count_all[ch]  = count;
        assign status_all[ch] = {(state == RUN), {(CNT_W-3){1'b0}}, done};
    end

    always_comb begin
        bus.rdata = '0;
        if (rd_en) begin
            case (bus.addr[2:1])
                2'd0:    bus.rdata = status_all[0];
                2'd1:    bus.rdata = status_all[1];
                2'd2:    bus.rdata = count_all[0];
                default: bus.rdata = count_all[1];
            endcase
        end
    end
endmodule
